vending_ctrl_param: RTL and testbench

Parametrised vending controller for an N-item machine with per-item prices set by parameter. It accepts nickel/dime/quarter coin inputs, tracks credit, vends the selected item, and returns change greedily as coin pulses. Cancel returns the full credit. It drives binary and two-digit BCD credit/price values straight into the board 4-digit seven-segment display block.

---
 rtl/vending_ctrl_param.sv | 176 +++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_param.sv
// Parametrised N-item vending controller: coin credit, purchase, greedy change payout
// and BCD views of credit/price for the seven-segment display block.
module vending_ctrl_param #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 7,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {7'd30, 7'd25, 7'd20, 7'd15},
  parameter int MAX_CREDIT = 95
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 N,
  input  logic                 D,
  input  logic                 Q,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  output logic [CREDIT_W-1:0]  credit,
  output logic [CREDIT_W-1:0]  price,
  output logic [7:0]           credit_bcd,
  output logic [7:0]           price_bcd,
  output logic                 vend,
  output logic [2:0]           vend_idx,
  output logic                 chg_n,
  output logic                 chg_d,
  output logic                 chg_q,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic                 busy
);

  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_prevN, r_prevD, r_prevQ, r_prevCancel;
  logic                r_coinReject;
  logic [2:0]          r_vendIdx;
  logic                r_gap;

  logic                w_edgeN, w_edgeD, w_edgeQ, w_edgeCancel, w_anyCoin;
  logic [SUM_W-1:0]    w_coinSum;
  logic                w_coinFits;
  logic                w_acceptState;
  logic                w_selOneHot;
  logic [CREDIT_W-1:0] w_price;
  logic [2:0]          w_selIdx;
  logic                w_purchase;
  logic [CREDIT_W-1:0] w_chgVal;

  function automatic logic [7:0] toBcd(input logic [CREDIT_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / CREDIT_W'(10));
    ones = 4'(v % CREDIT_W'(10));
    return {tens, ones};
  endfunction

  assign w_edgeN      = N & ~r_prevN;
  assign w_edgeD      = D & ~r_prevD;
  assign w_edgeQ      = Q & ~r_prevQ;
  assign w_edgeCancel = cancel & ~r_prevCancel;
  assign w_anyCoin    = w_edgeN | w_edgeD | w_edgeQ;

  // Coins arriving together are accepted or rejected as a single group.
  assign w_coinSum  = (w_edgeN ? SUM_W'(5)  : '0) +
                      (w_edgeD ? SUM_W'(10) : '0) +
                      (w_edgeQ ? SUM_W'(25) : '0);
  assign w_coinFits = ({1'b0, r_credit} + w_coinSum) <= SUM_W'(MAX_CREDIT);

  assign w_acceptState = (r_state == S_IDLE) || (r_state == S_COLLECT);

  assign w_selOneHot = (sel != '0) && ((sel & (sel - NUM_ITEMS'(1))) == '0);
  assign sel_err     = (sel != '0) && !w_selOneHot;

  always_comb begin
    w_price  = '0;
    w_selIdx = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel[i]) begin
        w_price  = PRICES[i*CREDIT_W +: CREDIT_W];
        w_selIdx = 3'(i);
      end
    end
    if (!w_selOneHot) begin
      w_price = '0;
    end
  end

  // A coin edge defers the purchase decision so the coin is credited first.
  assign w_purchase = w_acceptState && w_selOneHot && !w_anyCoin && (r_credit >= w_price);

  always_comb begin
    if (r_credit >= CREDIT_W'(25)) begin
      w_chgVal = CREDIT_W'(25);
    end else if (r_credit >= CREDIT_W'(10)) begin
      w_chgVal = CREDIT_W'(10);
    end else begin
      w_chgVal = CREDIT_W'(5);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_prevN      <= 1'b0;
      r_prevD      <= 1'b0;
      r_prevQ      <= 1'b0;
      r_prevCancel <= 1'b0;
      r_coinReject <= 1'b0;
      r_vendIdx    <= '0;
      r_gap        <= 1'b0;
    end else begin
      r_prevN      <= N;
      r_prevD      <= D;
      r_prevQ      <= Q;
      r_prevCancel <= cancel;
      r_coinReject <= w_anyCoin && !(w_acceptState && w_coinFits);
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (w_anyCoin) begin
            if (w_coinFits) begin
              r_credit <= r_credit + w_coinSum[CREDIT_W-1:0];
              r_state  <= S_COLLECT;
            end
            if (w_edgeCancel && (r_state == S_COLLECT)) begin
              r_state <= S_CHANGE;
              r_gap   <= 1'b0;
            end
          end else if (w_purchase) begin
            r_credit  <= r_credit - w_price;
            r_vendIdx <= w_selIdx;
            r_state   <= S_VEND;
          end else if (w_edgeCancel && (r_state == S_COLLECT)) begin
            r_state <= S_CHANGE;
            r_gap   <= 1'b0;
          end
        end
        S_VEND: begin
          r_gap   <= 1'b0;
          r_state <= (r_credit == '0) ? S_IDLE : S_CHANGE;
        end
        S_CHANGE: begin
          // Alternate pulse and gap cycles; leave only from a gap with nothing owed.
          if (!r_gap) begin
            r_credit <= r_credit - w_chgVal;
            r_gap    <= 1'b1;
          end else if (r_credit == '0) begin
            r_state <= S_IDLE;
            r_gap   <= 1'b0;
          end else begin
            r_gap <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign credit      = r_credit;
  assign price       = w_price;
  assign credit_bcd  = toBcd(r_credit);
  assign price_bcd   = toBcd(w_price);
  assign vend        = (r_state == S_VEND);
  assign vend_idx    = r_vendIdx;
  assign busy        = (r_state == S_VEND) || (r_state == S_CHANGE);
  assign coin_reject = r_coinReject;
  assign chg_q       = (r_state == S_CHANGE) && !r_gap && (w_chgVal == CREDIT_W'(25));
  assign chg_d       = (r_state == S_CHANGE) && !r_gap && (w_chgVal == CREDIT_W'(10));
  assign chg_n       = (r_state == S_CHANGE) && !r_gap && (w_chgVal == CREDIT_W'(5));

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: pulse outputs are scored against an expected-event queue,
// credit/price/status values are compared directly after each step.
module tb_vending_ctrl_param;

  localparam int EV_CHG_N  = 1;
  localparam int EV_CHG_D  = 2;
  localparam int EV_CHG_Q  = 3;
  localparam int EV_REJECT = 4;
  localparam int EV_VEND   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       N = 1'b0, D = 1'b0, Q = 1'b0, cancel = 1'b0;
  logic [3:0] sel = 4'b0000;
  logic [6:0] credit, price;
  logic [7:0] credit_bcd, price_bcd;
  logic       vend, chg_n, chg_d, chg_q, coin_reject, sel_err, busy;
  logic [2:0] vend_idx;

  int testsRun = 0;
  int failCount = 0;
  int expQ[$];

  vending_ctrl_param dut (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .sel(sel), .cancel(cancel),
    .credit(credit), .price(price), .credit_bcd(credit_bcd), .price_bcd(price_bcd),
    .vend(vend), .vend_idx(vend_idx), .chg_n(chg_n), .chg_d(chg_d), .chg_q(chg_q),
    .coin_reject(coin_reject), .sel_err(sel_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, observed, observed, expected, expected, $time);
    end
  endtask

  task automatic scoreEvent(input string tag, input int code);
    if (expQ.size() == 0) begin
      checkOutput({tag, "Unexpected"}, code, 0);
    end else begin
      checkOutput(tag, code, expQ.pop_front());
    end
  endtask

  // Every pulse seen on the outputs must match the next expected event in order.
  always @(negedge clk) begin
    if (vend)        scoreEvent("vend", EV_VEND + int'(vend_idx));
    if (chg_n)       scoreEvent("chgN", EV_CHG_N);
    if (chg_d)       scoreEvent("chgD", EV_CHG_D);
    if (chg_q)       scoreEvent("chgQ", EV_CHG_Q);
    if (coin_reject) scoreEvent("coinReject", EV_REJECT);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic n, input logic d, input logic q,
                               input logic c, input logic [3:0] s);
    N = n; D = d; Q = q; cancel = c; sel = s;
    #1;
  endtask

  task automatic insertCoin(input logic n, input logic d, input logic q);
    applyStimulus(n, d, q, 1'b0, sel);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, sel);
    tick();
  endtask

  initial begin
    tick();
    tick();
    checkOutput("resetCredit", int'(credit), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetVend", int'(vend), 0);
    checkOutput("resetReject", int'(coin_reject), 0);
    reset = 1'b1;
    tick();

    // Quarter, buy item 0 (15c), one dime back.
    insertCoin(1'b0, 1'b0, 1'b1);
    checkOutput("t1Credit", int'(credit), 25);
    checkOutput("t1CreditBcd", int'(credit_bcd), 'h25);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    expQ.push_back(EV_VEND + 0);
    expQ.push_back(EV_CHG_D);
    checkOutput("t1Price", int'(price), 15);
    checkOutput("t1PriceBcd", int'(price_bcd), 'h15);
    tick();
    checkOutput("t1VendBusy", int'(busy), 1);
    checkOutput("t1VendCredit", int'(credit), 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t1ChgD", int'(chg_d), 1);
    tick();
    checkOutput("t1AfterPulse", int'(credit), 0);
    tick();
    checkOutput("t1IdleBusy", int'(busy), 0);

    // Two dimes fall short of 25c; a nickel completes an exact purchase.
    insertCoin(1'b0, 1'b1, 1'b0);
    insertCoin(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    checkOutput("t2Price", int'(price), 25);
    tick();
    checkOutput("t2Credit20", int'(credit), 20);
    checkOutput("t2NoVend", int'(busy), 0);
    expQ.push_back(EV_VEND + 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    tick();
    checkOutput("t2Credit25", int'(credit), 25);
    checkOutput("t2Deferred", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    tick();
    checkOutput("t2VendBusy", int'(busy), 1);
    checkOutput("t2VendCredit", int'(credit), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t2BackIdle", int'(busy), 0);

    // 75c then cancel: three quarters with gaps.
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b0, 1'b1);
    checkOutput("t3Credit75", int'(credit), 75);
    repeat (3) expQ.push_back(EV_CHG_Q);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    checkOutput("t3Pulse1", int'(chg_q), 1);
    checkOutput("t3Credit75Chg", int'(credit), 75);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t3Credit50", int'(credit), 50);
    checkOutput("t3Gap1", int'(chg_q), 0);
    tick();
    checkOutput("t3Pulse2", int'(chg_q), 1);
    tick();
    checkOutput("t3Credit25", int'(credit), 25);
    tick();
    tick();
    checkOutput("t3Credit0", int'(credit), 0);
    checkOutput("t3StillBusy", int'(busy), 1);
    tick();
    checkOutput("t3Idle", int'(busy), 0);

    // Credit ceiling: reject over 95, accept up to 95, reject a simultaneous pair.
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b1, 1'b0);
    insertCoin(1'b1, 1'b0, 1'b0);
    checkOutput("t4Credit90", int'(credit), 90);
    expQ.push_back(EV_REJECT);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("t4RejectQ", int'(coin_reject), 1);
    checkOutput("t4Stay90", int'(credit), 90);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    insertCoin(1'b1, 1'b0, 1'b0);
    checkOutput("t4Credit95", int'(credit), 95);
    checkOutput("t4Bcd95", int'(credit_bcd), 'h95);
    expQ.push_back(EV_REJECT);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t4RejectND", int'(coin_reject), 1);
    checkOutput("t4Stay95", int'(credit), 95);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t4RejectOnce", int'(coin_reject), 0);
    repeat (3) expQ.push_back(EV_CHG_Q);
    repeat (2) expQ.push_back(EV_CHG_D);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (11) tick();
    checkOutput("t4Refunded", int'(credit), 0);
    checkOutput("t4Idle", int'(busy), 0);

    // Multi-bit select is an error with no price; coin during change is rejected.
    insertCoin(1'b0, 1'b0, 1'b1);
    insertCoin(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
    checkOutput("t5SelErr", int'(sel_err), 1);
    checkOutput("t5PriceZero", int'(price), 0);
    tick();
    tick();
    checkOutput("t5NoVendCredit", int'(credit), 50);
    checkOutput("t5NoVendBusy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("t5SelErrClear", int'(sel_err), 0);
    expQ.push_back(EV_CHG_Q);
    expQ.push_back(EV_REJECT);
    expQ.push_back(EV_CHG_Q);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("t5ChgCredit", int'(credit), 25);
    checkOutput("t5ChgReject", int'(coin_reject), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    checkOutput("t5CreditKept", int'(credit), 25);
    tick();
    tick();
    checkOutput("t5Idle", int'(busy), 0);
    checkOutput("t5Credit0", int'(credit), 0);

    // Asynchronous reset in the middle of a 15c refund.
    insertCoin(1'b0, 1'b1, 1'b0);
    insertCoin(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    checkOutput("t6Credit15", int'(credit), 15);
    checkOutput("t6Busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    checkOutput("t6AsyncCredit", int'(credit), 0);
    checkOutput("t6AsyncBusy", int'(busy), 0);
    checkOutput("t6AsyncChgD", int'(chg_d), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    checkOutput("t6PostCredit", int'(credit), 0);
    checkOutput("t6PostBusy", int'(busy), 0);

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
